// File: rtl/led_blink_pkg.sv
// Shared types and constant helpers for the LED blink driver.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  function automatic int unsigned cycles(input int unsigned ms, input int unsigned ticks);
    return ms * ticks;
  endfunction

  // Timer only has to hold 0..max-1, so a single-cycle window still needs one bit.
  function automatic int unsigned timer_width(input int unsigned on_c, input int unsigned off_c);
    int unsigned max_c;
    max_c = (on_c > off_c) ? on_c : off_c;
    return (max_c > 1) ? $clog2(max_c) : 1;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: IDLE/ON/OFF sequencer with a window timer and a blink counter.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned BLINK_BITS = 3,
  parameter int unsigned ON_CYCLES  = 10,
  parameter int unsigned OFF_CYCLES = 10,
  parameter int unsigned TIMER_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BLINK_BITS-1:0] count,
  output logic                  busy,
  output logic                  led_on
);

  localparam logic [TIMER_W-1:0] ON_END  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_END = TIMER_W'(OFF_CYCLES - 1);

  blink_state_t          state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BLINK_BITS-1:0] remaining_q, remaining_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          remaining_d = count;
          timer_d     = '0;
          state_d     = ON;
        end
      end
      ON: begin
        if (timer_q == ON_END) begin
          remaining_d = remaining_q - BLINK_BITS'(1);
          timer_d     = '0;
          state_d     = OFF;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      OFF: begin
        if (timer_q == OFF_END) begin
          timer_d = '0;
          state_d = (remaining_q == '0) ? IDLE : ON;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      busy        <= (state_q != IDLE);
    end
  end

  // Registered in the top together with the polarity inversion.
  assign led_on = (state_q == ON);

endmodule

// File: rtl/led_blink_driver.sv
// Multi-channel LED blink driver: turns single-cycle events into N visible blinks per channel.
module led_blink_driver
  import led_blink_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned BLINK_BITS   = 3,
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned ON_MS        = 200,
  parameter int unsigned OFF_MS       = 200,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic [CHANNELS-1:0]            start,
  input  logic [CHANNELS*BLINK_BITS-1:0] count,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            led_out
);

  localparam int unsigned ON_CYCLES  = cycles(ON_MS, TICKS_PER_MS);
  localparam int unsigned OFF_CYCLES = cycles(OFF_MS, TICKS_PER_MS);
  localparam int unsigned TIMER_W    = timer_width(ON_CYCLES, OFF_CYCLES);

  if ((ON_MS == 0) || (OFF_MS == 0)) begin : g_bad_timing
    $error("led_blink_driver: ON_MS and OFF_MS must both be non-zero");
  end

  logic [CHANNELS-1:0] led_on;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_blink_channel #(
      .BLINK_BITS (BLINK_BITS),
      .ON_CYCLES  (ON_CYCLES),
      .OFF_CYCLES (OFF_CYCLES),
      .TIMER_W    (TIMER_W)
    ) u_channel (
      .clk    (clk),
      .rst_n  (rstN),
      .start  (start[i]),
      .count  (count[i*BLINK_BITS +: BLINK_BITS]),
      .busy   (busy[i]),
      .led_on (led_on[i])
    );
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      led_out <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      led_out <= led_on ^ {CHANNELS{ACTIVE_LOW}};
    end
  end

endmodule
